// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_TYPE_BYTE = 1'b1;
  localparam logic MEM_TYPE_WORD = 1'b0;

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the assembled load data according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] rdata
);

  // Byte/halfword results are extended from bit 7/15; anything else is a full word.
  always_comb begin
    rdata = acc;
    case (funct3)
      F3_B:    rdata = {{(WIDTH-8){acc[7]}}, acc[7:0]};
      F3_H:    rdata = {{(WIDTH-16){acc[15]}}, acc[15:0]};
      F3_BU:   rdata = {{(WIDTH-8){1'b0}}, acc[7:0]};
      F3_HU:   rdata = {{(WIDTH-16){1'b0}}, acc[15:0]};
      default: rdata = acc;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the memory stage and a byte/word data memory.
// Halfwords and misaligned words are split into byte beats.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word requests
// issue no beats and complete immediately with resp_err set.
//
// state | meaning
// IDLE  | ready for a request; memory port quiet
// BEAT  | driving one memory beat per cycle (byte or single word)
// RESP  | one-cycle completion pulse with extended load data
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BEAT_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_we,
  output logic             mem_type,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int CW = $clog2(BEAT_MAX);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             word_q, word_d;
  logic [CW-1:0]    last_q, last_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic             is_byte, is_half, misaligned;
  logic [WIDTH-1:0] ext_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic             err_q, err_d;
`endif

  lsu_load_extend #(.WIDTH(WIDTH)) u_ext (
    .acc    (acc_q),
    .funct3 (f3_q),
    .rdata  (ext_rdata)
  );

  // Register update with synchronous reset; a request seen with rst high is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      word_q  <= 1'b0;
      last_q  <= '0;
      beat_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state: request latch and beat plan, beat stepping, load byte capture.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    acc_d      = acc_q;
    word_d     = word_q;
    last_d     = last_q;
    beat_d     = beat_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d      = err_q;
`endif
    is_byte    = (req_funct3[1:0] == F3_B[1:0]);
    is_half    = (req_funct3[1:0] == F3_H[1:0]);
    misaligned = (is_half && req_addr[0]) ||
                 (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          acc_d   = '0;
          beat_d  = '0;
          if (is_byte) begin
            word_d = 1'b0;
            last_d = '0;
          end else if (is_half) begin
            word_d = 1'b0;
            last_d = CW'(1);
          end else if (!misaligned) begin
            word_d = 1'b1;
            last_d = '0;
          end else begin
            word_d = 1'b0;
            last_d = CW'(BEAT_MAX - 1);
          end
`ifdef LSU_MISALIGN_TRAP_EN
          err_d   = misaligned;
          state_d = misaligned ? RESP : BEAT;
`else
          state_d = BEAT;
`endif
        end
      end
      BEAT: begin
        if (!we_q) begin
          if (word_q) acc_d = mem_rd;
          else        acc_d[8*beat_q +: 8] = mem_rd[7:0];
        end
        if (beat_q == last_q) state_d = RESP;
        else                  beat_d  = beat_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory port decode from registered state only.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_type   = MEM_TYPE_BYTE;
    mem_addr   = '0;
    mem_wd     = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      BEAT: begin
        mem_we   = we_q;
        mem_type = word_q ? MEM_TYPE_WORD : MEM_TYPE_BYTE;
        mem_addr = addr_q + WIDTH'(beat_q);
        mem_wd   = word_q ? wdata_q : {{(WIDTH-8){1'b0}}, wdata_q[8*beat_q +: 8]};
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : ext_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
        if (err_q) resp_rdata = '0;
`endif
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_err = (state_q == RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer with a byte-addressed memory model,
// an expected-beat queue and an expected-response scoreboard.
module tb_lsu_mem_sequencer;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we, mem_type;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  typedef struct {
    logic [31:0] addr;
    logic        typ;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  beat_t exp_beats[$];
  resp_t exp_resps[$];
  logic [7:0] mem [logic [31:0]];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  beat_t mon_b;
  resp_t mon_r;
  int c1, c2;

  always #5 clk = ~clk;

  lsu_mem_sequencer #(.WIDTH(32), .BEAT_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_type   (mem_type),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    mem[a] = d;
  endtask

  // Combinational memory read, refreshed on address/type change and every clock edge.
  always @(posedge clk or negedge clk or mem_addr or mem_type) begin
    if (mem_type == MEM_TYPE_WORD)
      mem_rd = {rdb(mem_addr + 32'd3), rdb(mem_addr + 32'd2), rdb(mem_addr + 32'd1), rdb(mem_addr)};
    else
      mem_rd = {24'h0, rdb(mem_addr)};
  end

  // Memory write commit on the clock edge, independent of the DUT reset.
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_type == MEM_TYPE_WORD) begin
        for (int i = 0; i < 4; i++) mem[mem_addr + i] = mem_wd[8*i +: 8];
      end else begin
        mem[mem_addr] = mem_wd[7:0];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: responses against scoreboard, beats against expected beat list.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (exp_resps.size() == 0) begin
          check("resp_unexpected", {31'b0, resp_valid}, 32'h0);
        end else begin
          mon_r = exp_resps.pop_front();
          check("resp_rdata", resp_rdata, mon_r.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, mon_r.err});
          check("resp_cycle", cyc, mon_r.cyc);
        end
      end else if (!req_ready) begin
        if (exp_beats.size() == 0) begin
          check("beat_unexpected", {31'b0, req_ready}, 32'h1);
        end else begin
          mon_b = exp_beats.pop_front();
          check("beat_addr", mem_addr, mon_b.addr);
          check("beat_type", {31'b0, mem_type}, {31'b0, mon_b.typ});
          check("beat_we", {31'b0, mem_we}, {31'b0, mon_b.we});
          if (mon_b.we) check("beat_wd", mem_wd, mon_b.wd);
        end
      end else begin
        check("idle_we", {31'b0, mem_we}, 32'h0);
        check("idle_type", {31'b0, mem_type}, 32'h1);
        check("idle_addr", mem_addr, 32'h0);
        check("idle_wd", mem_wd, 32'h0);
      end
    end
  end

  // Reference beat plan for one request; returns beat count and trap flag.
  task automatic plan(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output int n, output logic err);
    beat_t b;
    logic mis;
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1] && a[1:0] != 2'b00);
    err = 1'b0;
    n = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      err = 1'b1;
      return;
    end
`endif
    if (f3[1] && !mis) begin
      b.addr = a; b.typ = MEM_TYPE_WORD; b.we = we; b.wd = wd;
      exp_beats.push_back(b);
      n = 1;
    end else begin
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
        b.addr = a + k; b.typ = MEM_TYPE_BYTE; b.we = we; b.wd = {24'h0, wd[8*k +: 8]};
        exp_beats.push_back(b);
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, output int acc_cyc);
    int n;
    logic err;
    int k;
    resp_t r;
    k = 0;
    while (!req_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_timeout", {31'b0, req_ready}, 32'h1);
    plan(we, f3, a, wd, n, err);
    r.rdata = (we || err) ? 32'h0 : exp_rd;
    r.err   = err;
    r.cyc   = cyc + n + 1;
    exp_resps.push_back(r);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_resps.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", exp_resps.size(), 32'h0);
    exp_resps.delete();
    exp_beats.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a store request present; it must be ignored.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h10000; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_type", {31'b0, mem_type}, 32'h1);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ignored", {24'h0, rdb(32'h10000)}, 32'h0);

    // LW aligned, single word beat.
    poke(32'h10000, 8'h11); poke(32'h10001, 8'h22); poke(32'h10002, 8'h33); poke(32'h10003, 8'h44);
    issue(1'b0, F3_W, 32'h10000, 32'h0, 32'h4433_2211, c1); drain();

    // LB / LBU of 0x80.
    poke(32'h10003, 8'h80);
    issue(1'b0, F3_B, 32'h10003, 32'h0, 32'hFFFF_FF80, c1); drain();
    issue(1'b0, F3_BU, 32'h10003, 32'h0, 32'h0000_0080, c1); drain();

    // SH at odd address, then LHU back.
    poke(32'h10007, 8'h77);
    issue(1'b1, F3_H, 32'h10005, 32'hBEEF_5A5A, 32'h0, c1); drain();
    check("sh_keep_10007", {24'h0, rdb(32'h10007)}, 32'h77);
`ifndef LSU_MISALIGN_TRAP_EN
    check("sh_10005", {24'h0, rdb(32'h10005)}, 32'h5A);
    check("sh_10006", {24'h0, rdb(32'h10006)}, 32'h5A);
`endif
    issue(1'b0, F3_HU, 32'h10005, 32'h0, 32'h0000_5A5A, c1); drain();

    // Misaligned SW.
    issue(1'b1, F3_W, 32'h10001, 32'hDEAD_BEEF, 32'h0, c1); drain();
`ifndef LSU_MISALIGN_TRAP_EN
    check("sw_mis_10001", {24'h0, rdb(32'h10001)}, 32'hEF);
    check("sw_mis_10002", {24'h0, rdb(32'h10002)}, 32'hBE);
    check("sw_mis_10003", {24'h0, rdb(32'h10003)}, 32'hAD);
    check("sw_mis_10004", {24'h0, rdb(32'h10004)}, 32'hDE);
`else
    check("sw_trap_10001", {24'h0, rdb(32'h10001)}, 32'h22);
    check("sw_trap_10004", {24'h0, rdb(32'h10004)}, 32'h00);
`endif

    // LH wrapping past the top of the address space.
    poke(32'hFFFF_FFFF, 8'h34); poke(32'h0000_0000, 8'h92);
    issue(1'b0, F3_H, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_9234, c1); drain();

    // Aligned SW, aligned LH, funct3 011 treated as word, LBU.
    issue(1'b1, F3_W, 32'h10010, 32'hCAFE_F00D, 32'h0, c1); drain();
    issue(1'b0, F3_H, 32'h10012, 32'h0, 32'hFFFF_CAFE, c1); drain();
    issue(1'b0, 3'b011, 32'h10010, 32'h0, 32'hCAFE_F00D, c1); drain();
    issue(1'b0, F3_BU, 32'h10010, 32'h0, 32'h0000_000D, c1); drain();

    // SB only touches one byte.
    issue(1'b1, F3_B, 32'h10020, 32'h1234_56AB, 32'h0, c1); drain();
    issue(1'b0, F3_W, 32'h10020, 32'h0, 32'h0000_00AB, c1); drain();

    // Back-to-back throughput: N+2 cycles between acceptances.
    issue(1'b0, F3_BU, 32'h10020, 32'h0, 32'h0000_00AB, c1);
    issue(1'b0, F3_B, 32'h10020, 32'h0, 32'hFFFF_FFAB, c2);
    check("b2b_byte_spacing", c2 - c1, 32'd3);
    drain();
    issue(1'b0, F3_H, 32'h10012, 32'h0, 32'hFFFF_CAFE, c1);
    issue(1'b0, F3_W, 32'h10010, 32'h0, 32'hCAFE_F00D, c2);
    check("b2b_half_spacing", c2 - c1, 32'd4);
    drain();

`ifndef LSU_MISALIGN_TRAP_EN
    // Reset during the second beat of a 4-beat store.
    mon_b.addr = 32'h10041; mon_b.typ = MEM_TYPE_BYTE; mon_b.we = 1'b1; mon_b.wd = 32'h44;
    exp_beats.push_back(mon_b);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10041; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_ready", {31'b0, req_ready}, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("rstmid_10041", {24'h0, rdb(32'h10041)}, 32'h44);
    check("rstmid_10042", {24'h0, rdb(32'h10042)}, 32'h33);
    check("rstmid_10043", {24'h0, rdb(32'h10043)}, 32'h00);
    check("rstmid_10044", {24'h0, rdb(32'h10044)}, 32'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
